// File: rtl/add_share_sched.sv
// rtl/add_share_sched.sv - round-robin scheduler sharing one SIZE-bit adder for SIZE*CHUNKS-bit add/sub (option macro: ADD_SHARE_SUB_EN)
module add_share_sched #(
    parameter int SIZE   = 32,
    parameter int CHUNKS = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   REQ0_VALID,
    input  logic [SIZE*CHUNKS-1:0] REQ0_A,
    input  logic [SIZE*CHUNKS-1:0] REQ0_B,
    input  logic                   REQ0_SUB,
    input  logic                   REQ1_VALID,
    input  logic [SIZE*CHUNKS-1:0] REQ1_A,
    input  logic [SIZE*CHUNKS-1:0] REQ1_B,
    input  logic                   REQ1_SUB,
    output logic                   GNT0,
    output logic                   GNT1,
    output logic [SIZE-1:0]        ADD_A,
    output logic [SIZE-1:0]        ADD_B,
    output logic                   ADD_CIN,
    input  logic [SIZE-1:0]        ADD_SUM,
    input  logic                   ADD_COUT,
    output logic                   RES_VALID,
    input  logic                   RES_READY,
    output logic                   RES_ID,
    output logic [SIZE*CHUNKS-1:0] RES_SUM,
    output logic                   RES_COUT,
    output logic                   RES_OVF,
    output logic                   BUSY
);
    localparam int W  = SIZE * CHUNKS;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    res_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            ovf_q;
    logic            id_q;
    logic            last_q;     // requester granted most recently (1 after reset so 0 wins first)

    logic            pick1;
    logic            any_valid;
    logic            gnt0;
    logic            gnt1;
    logic [W-1:0]    b_cap;
    logic            cin0;

`ifdef ADD_SHARE_SUB_EN
    logic            sub_q;
    logic            sub_cap;
`else
    logic            unused_sub;
    assign unused_sub = REQ0_SUB ^ REQ1_SUB;
`endif

    // Round-robin pick; grant only in IDLE and never while reset is asserted
    always_comb begin
        any_valid = REQ0_VALID || REQ1_VALID;
        if (REQ0_VALID && REQ1_VALID) begin
            pick1 = ~last_q;
        end else begin
            pick1 = REQ1_VALID;
        end
        gnt0 = RST_N && (state_q == IDLE) && any_valid && !pick1;
        gnt1 = RST_N && (state_q == IDLE) && any_valid && pick1;
    end

    // Effective B operand (inverted for subtraction) and chunk-0 carry-in
    always_comb begin
`ifdef ADD_SHARE_SUB_EN
        sub_cap = pick1 ? REQ1_SUB : REQ0_SUB;
        b_cap   = (pick1 ? REQ1_B : REQ0_B) ^ {W{sub_cap}};
        cin0    = sub_q;
`else
        b_cap   = pick1 ? REQ1_B : REQ0_B;
        cin0    = 1'b0;
`endif
    end

    // Drive the shared adder with the current chunk only while running
    always_comb begin
        ADD_A   = '0;
        ADD_B   = '0;
        ADD_CIN = 1'b0;
        if (state_q == RUN) begin
            ADD_A   = a_q[cnt_q*SIZE +: SIZE];
            ADD_B   = b_q[cnt_q*SIZE +: SIZE];
            ADD_CIN = (cnt_q == '0) ? cin0 : carry_q;
        end
    end

    // Scheduler FSM: capture on grant, one adder pass per chunk, hold result until accepted
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
`ifdef ADD_SHARE_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q     <= pick1 ? REQ1_A : REQ0_A;
                        b_q     <= b_cap;
                        id_q    <= pick1;
                        cnt_q   <= '0;
`ifdef ADD_SHARE_SUB_EN
                        sub_q   <= sub_cap;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q[cnt_q*SIZE +: SIZE] <= ADD_SUM;
                    carry_q <= ADD_COUT;
                    if (cnt_q == LAST_CHUNK) begin
                        // Signed overflow from the top chunk's sign bits
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (ADD_SUM[SIZE-1] != a_q[W-1]);
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (RES_READY) begin
                        last_q  <= id_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign GNT0      = gnt0;
    assign GNT1      = gnt1;
    assign RES_VALID = (state_q == RESP);
    assign BUSY      = (state_q != IDLE);
    assign RES_ID    = id_q;
    assign RES_SUM   = res_q;
    assign RES_COUT  = carry_q;
    assign RES_OVF   = ovf_q;

endmodule

// File: tb/tb_add_share_sched.sv
// tb/tb_add_share_sched.sv - self-checking bench for add_share_sched (SIZE=32, CHUNKS=2)
module tb_add_share_sched;
    localparam int SIZE   = 32;
    localparam int CHUNKS = 2;
    localparam int W      = SIZE * CHUNKS;

    logic            CLK;
    logic            RST_N;
    logic            REQ0_VALID, REQ1_VALID;
    logic [W-1:0]    REQ0_A, REQ0_B, REQ1_A, REQ1_B;
    logic            REQ0_SUB, REQ1_SUB;
    logic            GNT0, GNT1;
    logic [SIZE-1:0] ADD_A, ADD_B, ADD_SUM;
    logic            ADD_CIN, ADD_COUT;
    logic            RES_VALID, RES_READY, RES_ID, RES_COUT, RES_OVF, BUSY;
    logic [W-1:0]    RES_SUM;

    int n_checks = 0;
    int n_fail   = 0;

    add_share_sched #(.SIZE(SIZE), .CHUNKS(CHUNKS)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_SUB(REQ0_SUB),
        .REQ1_VALID(REQ1_VALID), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_SUB(REQ1_SUB),
        .GNT0(GNT0), .GNT1(GNT1),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CIN(ADD_CIN),
        .ADD_SUM(ADD_SUM), .ADD_COUT(ADD_COUT),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_ID(RES_ID),
        .RES_SUM(RES_SUM), .RES_COUT(RES_COUT), .RES_OVF(RES_OVF), .BUSY(BUSY)
    );

    // External shared adder
    assign {ADD_COUT, ADD_SUM} = {1'b0, ADD_A} + {1'b0, ADD_B} + {{SIZE{1'b0}}, ADD_CIN};

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference: whole-word signed/unsigned arithmetic
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                                  output logic [W-1:0] sum, output bit cout, output bit ovf);
        logic signed [W+1:0] sa, sb, r;
        bit eff;
`ifdef ADD_SHARE_SUB_EN
        eff = sub;
`else
        eff = 1'b0;
`endif
        sa = $signed({{2{a[W-1]}}, a});
        sb = $signed({{2{b[W-1]}}, b});
        if (eff) begin
            sum  = a - b;
            cout = (a >= b);
            r    = sa - sb;
        end else begin
            sum  = a + b;
            cout = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
            r    = sa + sb;
        end
        ovf = (r != {{2{r[W-1]}}, r[W-1:0]});
    endfunction

    // Drives one request and observes it through to the response handshake
    task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                         output bit ok, output int lat, output logic [W-1:0] sum,
                         output bit cout, output bit ovf, output bit rid, output bit cin1);
        int n;
        ok = 0; lat = 0; sum = '0; cout = 0; ovf = 0; rid = 0; cin1 = 0;
        if (id) begin
            REQ1_VALID = 1; REQ1_A = a; REQ1_B = b; REQ1_SUB = sub;
        end else begin
            REQ0_VALID = 1; REQ0_A = a; REQ0_B = b; REQ0_SUB = sub;
        end
        #1;
        n = 0;
        while (!(id ? GNT1 : GNT0) && n < 20) begin
            tick(); #1; n++;
        end
        if (!(id ? GNT1 : GNT0)) begin
            REQ0_VALID = 0; REQ1_VALID = 0;
            return;
        end
        tick();
        REQ0_VALID = 0; REQ1_VALID = 0;
        #1;
        lat = 1;
        while (!RES_VALID && lat < 20) begin
            if (lat == 2) cin1 = ADD_CIN;
            tick(); #1; lat++;
        end
        if (!RES_VALID) return;
        ok = 1; sum = RES_SUM; cout = RES_COUT; ovf = RES_OVF; rid = RES_ID;
        tick();
    endtask

    task automatic test_reset();
        RST_N = 0; REQ0_VALID = 1; REQ1_VALID = 1;
        #1;
        n_checks++;
        if ({GNT0, GNT1, RES_VALID, RES_ID, RES_COUT, RES_OVF, BUSY, ADD_CIN} !== 8'h00 ||
            RES_SUM !== '0 || ADD_A !== '0 || ADD_B !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctl=%b sum=%h adda=%h addb=%h, required all zero",
                     {GNT0, GNT1, RES_VALID, RES_ID, RES_COUT, RES_OVF, BUSY, ADD_CIN}, RES_SUM, ADD_A, ADD_B);
        end
        tick(); tick();
        REQ0_VALID = 0; REQ1_VALID = 0;
        RST_N = 1;
        #1;
        n_checks++;
        if (BUSY !== 1'b0 || RES_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b res_valid=%b, required 0 0", BUSY, RES_VALID);
        end
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [W-1:0] es [3];
        bit ec [3];
        bit eo [3];
        bit ti [3];
        logic [W-1:0] sum;
        bit ok, cout, ovf, rid, cin1;
        int lat;
        ta[0] = 64'h00000000_FFFFFFFF; tb[0] = 64'h1; es[0] = 64'h00000001_00000000; ec[0] = 0; eo[0] = 0; ti[0] = 0;
        ta[1] = 64'h7FFFFFFF_FFFFFFFF; tb[1] = 64'h1; es[1] = 64'h80000000_00000000; ec[1] = 0; eo[1] = 1; ti[1] = 1;
        ta[2] = 64'hFFFFFFFF_FFFFFFFF; tb[2] = 64'h1; es[2] = 64'h0;                  ec[2] = 1; eo[2] = 0; ti[2] = 0;
        for (int i = 0; i < 3; i++) begin
            issue(ti[i], ta[i], tb[i], 1'b0, ok, lat, sum, cout, ovf, rid, cin1);
            n_checks++;
            if (!ok || lat != 3) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: ok=%0d lat=%0d, required ok=1 lat=3", i, ok, lat);
            end
            n_checks++;
            if (sum !== es[i] || cout !== ec[i] || ovf !== eo[i] || rid !== ti[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: sum=%h cout=%0d ovf=%0d id=%0d, required sum=%h cout=%0d ovf=%0d id=%0d",
                         i, sum, cout, ovf, rid, es[i], ec[i], eo[i], ti[i]);
            end
            if (i == 0) begin
                n_checks++;
                if (cin1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL directed_chunk1_cin: ADD_CIN=%0d, required 1", cin1);
                end
            end
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] sum, es;
        bit ok, cout, ovf, rid, cin1;
        bit ec, eo;
        int lat;
        issue(1'b0, 64'd5, 64'd7, 1'b1, ok, lat, sum, cout, ovf, rid, cin1);
`ifdef ADD_SHARE_SUB_EN
        es = 64'hFFFFFFFF_FFFFFFFE; ec = 0; eo = 0;
`else
        es = 64'd12; ec = 0; eo = 0;
`endif
        n_checks++;
        if (!ok || sum !== es || cout !== ec || ovf !== eo) begin
            n_fail++;
            $display("FAIL sub_5_minus_7: ok=%0d sum=%h cout=%0d ovf=%0d, required sum=%h cout=%0d ovf=%0d",
                     ok, sum, cout, ovf, es, ec, eo);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, sum, es;
        bit ok, cout, ovf, rid, cin1, ec, eo, id, sub;
        int lat;
        for (int i = 0; i < 40; i++) begin
            id  = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            a   = rand64();
            case ($urandom_range(0, 3))
                0: b = ~a;
                1: b = a;
                2: b = {{(W-1){1'b0}}, 1'b1};
                default: b = rand64();
            endcase
            model(a, b, sub, es, ec, eo);
            issue(id, a, b, sub, ok, lat, sum, cout, ovf, rid, cin1);
            n_checks++;
            if (!ok || lat != CHUNKS + 1 || sum !== es || cout !== ec || ovf !== eo || rid !== id) begin
                n_fail++;
                $display("FAIL random[%0d]: a=%h b=%h sub=%0d ok=%0d lat=%0d sum=%h cout=%0d ovf=%0d id=%0d, required lat=%0d sum=%h cout=%0d ovf=%0d id=%0d",
                         i, a, b, sub, ok, lat, sum, cout, ovf, rid, CHUNKS + 1, es, ec, eo, id);
            end
        end
    endtask

    task automatic test_round_robin();
        int gcyc[$];
        int gid[$];
        logic [W-1:0] es;
        bit ec, eo;
        int cyc;
        int bad;
        RES_READY = 1;
        RST_N = 0;
        REQ0_A = rand64(); REQ0_B = rand64(); REQ0_SUB = 0;
        REQ1_A = rand64(); REQ1_B = rand64(); REQ1_SUB = 0;
        REQ0_VALID = 1; REQ1_VALID = 1;
        tick(); tick();
        RST_N = 1;
        #1;
        bad = 0;
        for (cyc = 0; cyc < 40 && gid.size() < 4; cyc++) begin
            if (GNT0 && GNT1) bad++;
            if (GNT0) begin gid.push_back(0); gcyc.push_back(cyc); end
            if (GNT1) begin gid.push_back(1); gcyc.push_back(cyc); end
            if (RES_VALID) begin
                if (RES_ID) model(REQ1_A, REQ1_B, 1'b0, es, ec, eo);
                else        model(REQ0_A, REQ0_B, 1'b0, es, ec, eo);
                if (RES_SUM !== es || RES_COUT !== ec || RES_OVF !== eo) bad++;
            end
            tick(); #1;
        end
        REQ0_VALID = 0; REQ1_VALID = 0;
        for (int i = 0; i < 10 && BUSY; i++) begin
            tick(); #1;
        end
        n_checks++;
        if (gid.size() != 4) begin
            n_fail++;
            $display("FAIL rr_grant_count: grants=%0d, required 4", gid.size());
        end else begin
            n_checks++;
            if (gid[0] != 0 || gid[1] != 1 || gid[2] != 0 || gid[3] != 1) begin
                n_fail++;
                $display("FAIL rr_order: order=%0d%0d%0d%0d, required 0101", gid[0], gid[1], gid[2], gid[3]);
            end
            n_checks++;
            if (gcyc[1] - gcyc[0] != CHUNKS + 2 || gcyc[2] - gcyc[1] != CHUNKS + 2 || gcyc[3] - gcyc[2] != CHUNKS + 2) begin
                n_fail++;
                $display("FAIL rr_spacing: gaps=%0d,%0d,%0d, required %0d", gcyc[1] - gcyc[0],
                         gcyc[2] - gcyc[1], gcyc[3] - gcyc[2], CHUNKS + 2);
            end
        end
        n_checks++;
        if (bad != 0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_results: bad=%0d busy=%b, required bad=0 busy=0", bad, BUSY);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, es, es1;
        bit ec, eo, ec1, eo1;
        int n;
        int bad;
        a = rand64(); b = rand64();
        model(a, b, 1'b0, es, ec, eo);
        RES_READY = 0;
        REQ0_VALID = 1; REQ0_A = a; REQ0_B = b; REQ0_SUB = 0;
        #1;
        n = 0;
        while (!GNT0 && n < 20) begin tick(); #1; n++; end
        tick();
        REQ0_VALID = 0;
        REQ1_A = rand64(); REQ1_B = rand64(); REQ1_SUB = 0; REQ1_VALID = 1;
        model(REQ1_A, REQ1_B, 1'b0, es1, ec1, eo1);
        #1;
        n = 0;
        while (!RES_VALID && n < 20) begin tick(); #1; n++; end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (RES_VALID !== 1'b1 || BUSY !== 1'b1 || GNT0 !== 1'b0 || GNT1 !== 1'b0 ||
                RES_SUM !== es || RES_COUT !== ec || RES_OVF !== eo || RES_ID !== 1'b0) bad++;
            tick(); #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d of 5 stalled cycles wrong (valid=%b busy=%b sum=%h), required valid=1 busy=1 sum=%h no grant",
                     bad, RES_VALID, BUSY, RES_SUM, es);
        end
        RES_READY = 1;
        n_checks++;
        if (RES_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_still_valid: res_valid=%b, required 1", RES_VALID);
        end
        tick(); #1;
        n_checks++;
        if (RES_VALID !== 1'b0 || GNT1 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: res_valid=%b gnt1=%b, required 0 1", RES_VALID, GNT1);
        end
        tick();
        REQ1_VALID = 0;
        #1;
        n = 0;
        while (!RES_VALID && n < 20) begin tick(); #1; n++; end
        n_checks++;
        if (RES_VALID !== 1'b1 || RES_ID !== 1'b1 || RES_SUM !== es1 || RES_COUT !== ec1 || RES_OVF !== eo1) begin
            n_fail++;
            $display("FAIL bp_next_op: valid=%b id=%b sum=%h, required valid=1 id=1 sum=%h", RES_VALID, RES_ID, RES_SUM, es1);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] a, b;
        int n;
        int bad;
        a = 64'h12345678_9ABCDEF0; b = 64'h0F0F0F0F_11111111;
        REQ0_VALID = 1; REQ0_A = a; REQ0_B = b; REQ0_SUB = 0;
        #1;
        n = 0;
        while (!GNT0 && n < 20) begin tick(); #1; n++; end
        tick();
        REQ0_VALID = 0;
        tick();
        #1;
        n_checks++;
        if (BUSY !== 1'b1 || ADD_A !== a[2*SIZE-1:SIZE]) begin
            n_fail++;
            $display("FAIL rst_run_precond: busy=%b add_a=%h, required 1 %h", BUSY, ADD_A, a[2*SIZE-1:SIZE]);
        end
        RST_N = 0;
        #1;
        n_checks++;
        if ({GNT0, GNT1, RES_VALID, RES_ID, RES_COUT, RES_OVF, BUSY, ADD_CIN} !== 8'h00 ||
            RES_SUM !== '0 || ADD_A !== '0 || ADD_B !== '0) begin
            n_fail++;
            $display("FAIL rst_run_outputs: ctl=%b sum=%h adda=%h addb=%h, required all zero",
                     {GNT0, GNT1, RES_VALID, RES_ID, RES_COUT, RES_OVF, BUSY, ADD_CIN}, RES_SUM, ADD_A, ADD_B);
        end
        tick(); tick();
        RST_N = 1;
        #1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (RES_VALID !== 1'b0 || BUSY !== 1'b0 || GNT0 !== 1'b0 || GNT1 !== 1'b0) bad++;
            tick(); #1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_run_no_response: %0d bad idle cycles, required 0", bad);
        end
    endtask

    initial begin
        CLK = 0; RST_N = 0; RES_READY = 1;
        REQ0_VALID = 0; REQ1_VALID = 0; REQ0_SUB = 0; REQ1_SUB = 0;
        REQ0_A = '0; REQ0_B = '0; REQ1_A = '0; REQ1_B = '0;
        test_reset();
        test_directed();
        test_sub();
        test_random();
        test_round_robin();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
